// File: rtl/nic_fifo.sv
// NIC between a processing element and its mesh router port: input FIFO (router->CPU),
// output FIFO (CPU->router), occupancy status words and a sticky drop flag for CPU writes.
module nic_fifo #(
  parameter int PACKET_WIDTH = 64,
  parameter int IN_DEPTH     = 4,
  parameter int OUT_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              addr,
  input  logic [PACKET_WIDTH-1:0] d_in,
  output logic [PACKET_WIDTH-1:0] d_out,
  input  logic                    nicEn,
  input  logic                    nicEnWR,
  input  logic                    net_si,
  output logic                    net_ri,
  input  logic [PACKET_WIDTH-1:0] net_di,
  output logic                    net_so,
  input  logic                    net_ro,
  output logic [PACKET_WIDTH-1:0] net_do,
  input  logic                    net_polarity
);

  localparam int ICW = $clog2(IN_DEPTH + 1);
  localparam int OCW = $clog2(OUT_DEPTH + 1);
  localparam int IPW = $clog2(IN_DEPTH);
  localparam int OPW = $clog2(OUT_DEPTH);

  function automatic logic [IPW-1:0] in_ptr_inc(input logic [IPW-1:0] p);
    return (p == IPW'(IN_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [OPW-1:0] out_ptr_inc(input logic [OPW-1:0] p);
    return (p == OPW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PACKET_WIDTH-1:0] in_status(input logic [ICW-1:0] cnt);
    logic [PACKET_WIDTH-1:0] s;
    s        = '0;
    s[ICW:1] = cnt;
    s[0]     = (cnt != '0);
    return s;
  endfunction

  function automatic logic [PACKET_WIDTH-1:0] out_status(input logic [OCW-1:0] cnt,
                                                          input logic ovf);
    logic [PACKET_WIDTH-1:0] s;
    s                 = '0;
    s[PACKET_WIDTH-1] = ovf;
    s[OCW:1]          = cnt;
    s[0]              = (cnt == OCW'(OUT_DEPTH));
    return s;
  endfunction

  logic [PACKET_WIDTH-1:0] r_in_mem  [IN_DEPTH];
  logic [PACKET_WIDTH-1:0] r_out_mem [OUT_DEPTH];
  logic [IPW-1:0]          r_in_head, r_in_tail;
  logic [OPW-1:0]          r_out_head, r_out_tail;
  logic [ICW-1:0]          r_in_count;
  logic [OCW-1:0]          r_out_count;
  logic                    r_ovf;
  logic [PACKET_WIDTH-1:0] r_d_out, r_net_do;
  logic                    r_net_so, r_net_ri;

  logic           w_rd, w_wr_out, w_in_push, w_in_pop, w_send, w_out_push, w_drop;
  logic [ICW-1:0] w_in_count_next;

  assign w_rd       = nicEn && !nicEnWR;
  assign w_wr_out   = nicEn && nicEnWR && (addr == 2'b10);
  assign w_in_push  = net_si && r_net_ri;
  assign w_in_pop   = w_rd && (addr == 2'b00) && (r_in_count != '0);
  assign w_send     = (r_out_count != '0) && net_ro && net_polarity;
  // A full output FIFO still accepts a write on the edge that sends a packet out.
  assign w_out_push = w_wr_out && ((r_out_count < OCW'(OUT_DEPTH)) || w_send);
  assign w_drop     = w_wr_out && !w_out_push;
  assign w_in_count_next = r_in_count + ICW'(w_in_push) - ICW'(w_in_pop);

  always_ff @(posedge clk) begin
    if (w_in_push) r_in_mem[r_in_tail] <= net_di;
    if (w_out_push) r_out_mem[r_out_tail] <= d_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_head   <= '0;
      r_in_tail   <= '0;
      r_in_count  <= '0;
      r_out_head  <= '0;
      r_out_tail  <= '0;
      r_out_count <= '0;
      r_ovf       <= 1'b0;
      r_net_ri    <= 1'b1;
    end else begin
      if (w_in_push) r_in_tail <= in_ptr_inc(r_in_tail);
      if (w_in_pop)  r_in_head <= in_ptr_inc(r_in_head);
      r_in_count <= w_in_count_next;
      r_net_ri   <= (w_in_count_next < ICW'(IN_DEPTH));
      if (w_out_push) r_out_tail <= out_ptr_inc(r_out_tail);
      if (w_send)     r_out_head <= out_ptr_inc(r_out_head);
      r_out_count <= r_out_count + OCW'(w_out_push) - OCW'(w_send);
      if (w_drop)
        r_ovf <= 1'b1;
      else if (w_rd && (addr == 2'b11))
        r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_d_out  <= '0;
      r_net_do <= '0;
      r_net_so <= 1'b0;
    end else begin
      if (w_rd) begin
        case (addr)
          2'b00:   r_d_out <= (r_in_count != '0) ? r_in_mem[r_in_head] : '0;
          2'b01:   r_d_out <= in_status(r_in_count);
          2'b10:   r_d_out <= '0;
          default: r_d_out <= out_status(r_out_count, r_ovf);
        endcase
      end
      r_net_so <= w_send;
      if (w_send) r_net_do <= r_out_mem[r_out_head];
    end
  end

  assign d_out  = r_d_out;
  assign net_do = r_net_do;
  assign net_so = r_net_so;
  assign net_ri = r_net_ri;

endmodule
